fetchu: RTL and testbench

FETCHU -- requirements
Module: fetchu

---
 rtl/rv_pkg.sv | 16 +
 rtl/fetchu_if.sv | 22 ++
 rtl/fetchu_fifo.sv | 86 ++++++++
 rtl/fetchu.sv | 169 ++++++++++++++++
 tb/tb_fetchu.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch-path types and defaults.
// Holds the default PC/instruction widths, the reset PC, and the
// {pc, instr} layout of one fetch buffer entry.
package rv_pkg;

  localparam int          RV_AW       = 32;
  localparam int          RV_DW       = 32;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  // One fetch buffer entry: PC in the upper half, instruction word below.
  typedef struct packed {
    logic [RV_AW-1:0] pc;
    logic [RV_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetchu_if.sv
// fetchu_if: instruction memory request/response bus.
// master = fetch unit side, slave = memory side.
interface fetchu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          o_imem_req;
  logic [AW-1:0] o_imem_addr;
  logic          i_imem_gnt;
  logic          i_imem_rvalid;
  logic [DW-1:0] i_imem_rdata;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );
endinterface

// File: rtl/fetchu_fifo.sv
// fetchu_fifo: small synchronous FIFO with flush, used both as the
// in-flight PC queue and as the instruction buffer. Depth need not be a
// power of two; pointers wrap explicitly at DEPTH-1.
module fetchu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == {CW{1'b0}});
  assign count = cnt_q;

  // Next pointers, occupancy and storage; flush drops every entry.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = {PW{1'b0}};
      wr_d  = {PW{1'b0}};
      cnt_d = {CW{1'b0}};
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = ptr_inc(wr_q);
      end else begin
        wr_d = wr_q;
      end
      if (pop) begin
        rd_d = ptr_inc(rd_q);
      end else begin
        rd_d = rd_q;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1'b1);
        2'b01:   cnt_d = cnt_q - CW'(1'b1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      rd_q  <= {PW{1'b0}};
      wr_q  <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetchu.sv
// fetchu: instruction fetch unit. Issues in-order word fetches under a
// credit limit, pairs each response with its PC and presents entries to
// decode through a small buffer. A jump flushes everything and drops the
// responses still in flight.
// Optional feature macro: FETCHU_MISALIGN_EN (adds o_misalign; a jump to a
// non-word-aligned target halts fetching until the next jump).
module fetchu
  import rv_pkg::*;
#(
  parameter int            AW        = RV_AW,
  parameter int            DW        = RV_DW,
  parameter logic [AW-1:0] RESET_PC  = AW'(RV_RESET_PC),
  parameter int            BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetchu_if.master      imem,
  input  logic          i_jump_valid,
  input  logic [AW-1:0] i_jump_pc,
  input  logic          i_holding,
  output logic          o_valid,
  output logic [AW-1:0] o_pc,
  output logic [DW-1:0] o_instr
`ifdef FETCHU_MISALIGN_EN
  ,
  output logic          o_misalign
`endif
);
  localparam int          CW         = $clog2(BUF_DEPTH + 1);
  localparam logic [1:0]  ST_BOOT    = 2'd0;
  localparam logic [1:0]  ST_RUN     = 2'd1;
  localparam logic [1:0]  ST_DRAIN   = 2'd2;
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(BUF_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [CW-1:0]    outst_q, outst_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [CW-1:0]    jump_drop_s, buf_cnt_s;
  logic [CW:0]      occupancy_s;
  logic             fetch_on_s, req_s, grant_s, rsp_s;
  logic             drop_now_s, keep_s, pop_s, buf_empty_s, fetch_block_s;
  logic [AW-1:0]    jump_tgt_s, pcq_head_s;
  logic [AW+DW-1:0] buf_head_s;
  logic [CW-1:0]    pcq_cnt_unused;
  logic             pcq_empty_unused;

`ifdef FETCHU_MISALIGN_EN
  logic misalign_q, misalign_d;

  assign fetch_block_s = misalign_q;
  assign jump_tgt_s    = i_jump_pc;
  assign o_misalign    = !rst && misalign_q;

  // Misalign flag follows the alignment of the most recent jump target.
  always_comb begin
    if (i_jump_valid) begin
      misalign_d = (i_jump_pc[1:0] != 2'b00);
    end else begin
      misalign_d = misalign_q;
    end
  end

  // Misalign flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  logic jump_lsb_unused;

  assign fetch_block_s   = 1'b0;
  assign jump_tgt_s      = {i_jump_pc[AW-1:2], 2'b00};
  assign jump_lsb_unused = ^i_jump_pc[1:0];
`endif

  // Credit: requests in flight plus buffered entries never exceed the buffer.
  assign rsp_s       = imem.i_imem_rvalid;
  assign fetch_on_s  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign occupancy_s = {1'b0, outst_q} + {1'b0, buf_cnt_s};
  assign req_s       = !rst && fetch_on_s && !i_jump_valid && !fetch_block_s &&
                       (occupancy_s < CREDIT_MAX);
  assign grant_s     = req_s && imem.i_imem_gnt;
  // A response is stale while drops are pending or when a jump lands with it.
  assign drop_now_s  = rsp_s && (drop_q != {CW{1'b0}});
  assign keep_s      = rsp_s && !drop_now_s && !i_jump_valid;
  // The response arriving with the jump is discarded now, so it is not re-counted.
  assign jump_drop_s = outst_q - CW'(rsp_s);
  assign pop_s       = o_valid && !i_holding && !i_jump_valid;

  assign imem.o_imem_req  = req_s;
  assign imem.o_imem_addr = pc_q;
  assign o_valid          = !rst && !buf_empty_s && !fetch_block_s;
  assign o_pc             = rst ? {AW{1'b0}} : buf_head_s[AW+DW-1:DW];
  assign o_instr          = rst ? {DW{1'b0}} : buf_head_s[DW-1:0];

  // Next fetch PC, in-flight/drop counters and control state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    outst_d = outst_q + CW'(grant_s) - CW'(rsp_s);
    if (i_jump_valid) begin
      pc_d    = jump_tgt_s;
      drop_d  = jump_drop_s;
      state_d = (jump_drop_s != {CW{1'b0}}) ? ST_DRAIN : ST_RUN;
    end else begin
      if (grant_s) begin
        pc_d = pc_q + AW'(3'd4);
      end else begin
        pc_d = pc_q;
      end
      if (drop_now_s) begin
        drop_d = drop_q - CW'(1'b1);
      end else begin
        drop_d = drop_q;
      end
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_DRAIN: state_d = (drop_d == {CW{1'b0}}) ? ST_RUN : ST_DRAIN;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      outst_q <= {CW{1'b0}};
      drop_q  <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  fetchu_fifo #(.W(AW), .DEPTH(BUF_DEPTH), .CW(CW)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .flush (i_jump_valid),
    .push  (grant_s),
    .din   (pc_q),
    .pop   (keep_s),
    .dout  (pcq_head_s),
    .empty (pcq_empty_unused),
    .count (pcq_cnt_unused)
  );

  fetchu_fifo #(.W(AW + DW), .DEPTH(BUF_DEPTH), .CW(CW)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (i_jump_valid),
    .push  (keep_s),
    .din   ({pcq_head_s, imem.i_imem_rdata}),
    .pop   (pop_s),
    .dout  (buf_head_s),
    .empty (buf_empty_s),
    .count (buf_cnt_s)
  );

endmodule

// File: tb/tb_fetchu.sv
// tb_fetchu: randomized bench for fetchu with a queue-based reference model.
// Honours FETCHU_MISALIGN_EN when defined.
module tb_fetchu;
  import rv_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    bit          live;
    int          gcyc;
  } fl_t;

  logic        clk = 1'b0;
  logic        rst, jv, hold;
  logic [31:0] jpc;
  logic        o_valid;
  logic [31:0] o_pc, o_instr;
`ifdef FETCHU_MISALIGN_EN
  logic        o_mis;
`endif

  always #5 clk = ~clk;

  fetchu_if #(.AW(AW), .DW(DW)) bus ();

  fetchu #(.AW(AW), .DW(DW), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .i_jump_valid (jv),
    .i_jump_pc    (jpc),
    .i_holding    (hold),
    .o_valid      (o_valid),
    .o_pc         (o_pc),
    .o_instr      (o_instr)
`ifdef FETCHU_MISALIGN_EN
    ,
    .o_misalign   (o_mis)
`endif
  );

  // Reference model state
  fl_t          fl[$];
  fetch_entry_t mbuf[$];
  logic [31:0]  fpc;
  bit           started, mmis, chk_en, junk_rv;
  int           cyc, rprob, total, bad;
  logic         n_rst, n_jv, n_hold, n_gnt;
  logic [31:0]  n_jpc;
  logic         exp_req, exp_valid, exp_mis;
  logic [31:0]  exp_addr, exp_pc, exp_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // One clock: advance the model with the cycle just ended, apply the next
  // inputs, answer from the memory side, then form expectations.
  task automatic tick();
    fl_t e;
    @(posedge clk);
    if (rst) begin
      fl.delete(); mbuf.delete(); fpc = 32'h0; started = 0; mmis = 0;
    end else begin
      if (mbuf.size() > 0 && !hold && !jv && !mmis) void'(mbuf.pop_front());
      if (bus.i_imem_rvalid && fl.size() > 0) begin
        e = fl.pop_front();
        if (e.live && !jv) mbuf.push_back('{pc: e.addr, instr: mem_word(e.addr)});
      end
      if (exp_req && bus.i_imem_gnt) begin
        fl.push_back('{addr: fpc, live: 1'b1, gcyc: cyc});
        fpc += 32'd4;
      end
      if (jv) begin
        foreach (fl[i]) fl[i].live = 1'b0;
        mbuf.delete();
`ifdef FETCHU_MISALIGN_EN
        mmis = (jpc[1:0] != 2'b00);
        fpc  = jpc;
`else
        fpc  = {jpc[31:2], 2'b00};
`endif
      end
      started = 1;
    end
    cyc++;
    #1;
    rst = n_rst; jv = n_jv; jpc = n_jpc; hold = n_hold; bus.i_imem_gnt = n_gnt;
    if (!rst && fl.size() > 0 && fl[0].gcyc < cyc && $urandom_range(99) < rprob) begin
      bus.i_imem_rvalid = 1'b1; bus.i_imem_rdata = mem_word(fl[0].addr);
    end else if (rst && junk_rv) begin
      bus.i_imem_rvalid = 1'b1; bus.i_imem_rdata = 32'hBAD0_BAD0;
    end else begin
      bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = $urandom;
    end
    exp_req   = !rst && started && !jv && !mmis && (fl.size() + mbuf.size() < DEPTH);
    exp_addr  = fpc;
    exp_valid = !rst && (mbuf.size() > 0) && !mmis;
    exp_pc    = exp_valid ? mbuf[0].pc : 32'h0;
    exp_instr = exp_valid ? mbuf[0].instr : 32'h0;
    exp_mis   = !rst && mmis;
    chk_en    = 1;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int lim, output bit found);
    found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      tick();
      if (o_valid) found = 1;
    end
  endtask

  // Compare DUT outputs against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", bus.o_imem_req, exp_req);
      if (exp_req) chk("addr", bus.o_imem_addr, exp_addr);
      chk("valid", o_valid, exp_valid);
      if (exp_valid || rst) begin
        chk("pc", o_pc, exp_pc);
        chk("instr", o_instr, exp_instr);
      end
`ifdef FETCHU_MISALIGN_EN
      chk("misalign", o_mis, exp_mis);
`endif
    end
  end

  initial begin
    logic [31:0] addrs[3];
    int          nreq, first_req, first_val;
    logic [31:0] fv_pc;
    bit          found, saw8;

    rst = 1'b1; jv = 1'b0; jpc = 32'h0; hold = 1'b0;
    bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = 32'h0;
    n_rst = 1'b1; n_jv = 1'b0; n_jpc = 32'h0; n_hold = 1'b0; n_gnt = 1'b0;
    fpc = 32'h0; started = 0; mmis = 0; chk_en = 0; cyc = 0; total = 0; bad = 0;
    exp_req = 1'b0; exp_valid = 1'b0; exp_mis = 1'b0;
    exp_addr = 32'h0; exp_pc = 32'h0; exp_instr = 32'h0;
    rprob = 0; junk_rv = 1;

    // Reset with a stray response during reset
    repeat (3) tick();
    junk_rv = 0;

    // Boot: 0x0, 0x4, 0x8; first o_valid two cycles after the first request
    n_rst = 1'b0; n_gnt = 1'b1; rprob = 100;
    foreach (addrs[i]) addrs[i] = 32'hDEAD_DEAD;
    nreq = 0; first_req = -100; first_val = -1; fv_pc = 32'hDEAD_DEAD;
    repeat (10) begin
      tick();
      if (bus.o_imem_req && bus.i_imem_gnt && nreq < 3) begin
        addrs[nreq] = bus.o_imem_addr;
        if (nreq == 0) first_req = cyc;
        nreq++;
      end
      if (o_valid && first_val < 0) begin
        first_val = cyc; fv_pc = o_pc;
      end
    end
    chk("boot_req0", addrs[0], 32'h0);
    chk("boot_req1", addrs[1], 32'h4);
    chk("boot_req2", addrs[2], 32'h8);
    chk("first_valid_latency", first_val - first_req, 2);
    chk("first_pc", fv_pc, 32'h0);

    // Decode holds for 5 cycles: buffer fills, requests stop
    n_hold = 1'b1;
    repeat (5) tick();
    chk("hold_req_low", bus.o_imem_req, 1'b0);
    chk("hold_valid", o_valid, 1'b1);
    n_hold = 1'b0;
    repeat (6) tick();

    // Two outstanding, then jump to 0x100: both responses dropped
    rprob = 0;
    repeat (6) tick();
    n_jv = 1'b1; n_jpc = 32'h100;
    tick();
    chk("jump_req_low", bus.o_imem_req, 1'b0);
    n_jv = 1'b0; rprob = 100;
    wait_valid(20, found);
    chk("jump_found", found, 1'b1);
    chk("jump_pc", o_pc, 32'h100);
    chk("jump_instr", o_instr, mem_word(32'h100));

    // Jump in the same cycle as the response for 0x8
    n_rst = 1'b1; tick(); tick();
    n_rst = 1'b0; rprob = 100;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.o_imem_req && bus.o_imem_addr == 32'h8) found = 1;
    end
    chk("saw_req8", found, 1'b1);
    rprob = 0;
    tick();
    chk("req_c", {bus.o_imem_req, bus.o_imem_addr}, {1'b1, 32'hC});
    n_jv = 1'b1; n_jpc = 32'h40; rprob = 100;
    tick();
    n_jv = 1'b0;
    saw8 = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_valid && o_pc == 32'h8) saw8 = 1;
      if (o_valid) found = 1;
    end
    chk("no_pc8", saw8, 1'b0);
    chk("drain_pc", o_pc, 32'h40);

    // PC wraps from 0xFFFF_FFFC to 0x0
    n_jv = 1'b1; n_jpc = 32'hFFFF_FFFC;
    tick();
    n_jv = 1'b0;
    foreach (addrs[i]) addrs[i] = 32'hDEAD_DEAD;
    nreq = 0;
    for (int i = 0; i < 20 && nreq < 2; i++) begin
      tick();
      if (bus.o_imem_req && bus.i_imem_gnt) begin
        addrs[nreq] = bus.o_imem_addr; nreq++;
      end
    end
    chk("wrap_req0", addrs[0], 32'hFFFF_FFFC);
    chk("wrap_req1", addrs[1], 32'h0);

`ifdef FETCHU_MISALIGN_EN
    // Misaligned jump halts fetching until a jump to 0x200
    n_jv = 1'b1; n_jpc = 32'h102;
    tick();
    n_jv = 1'b0;
    repeat (4) tick();
    chk("mis_flag", o_mis, 1'b1);
    chk("mis_req", bus.o_imem_req, 1'b0);
    chk("mis_valid", o_valid, 1'b0);
    n_jv = 1'b1; n_jpc = 32'h200;
    tick();
    n_jv = 1'b0;
    wait_valid(20, found);
    chk("mis_clear", o_mis, 1'b0);
    chk("mis_pc", o_pc, 32'h200);
`endif

    // Randomized traffic with an intermediate reset
    for (int k = 0; k < 4000; k++) begin
      if (k % 200 == 0) rprob = $urandom_range(100, 20);
      n_gnt  = ($urandom_range(99) < 70);
      n_hold = ($urandom_range(99) < 30);
      n_jv   = ($urandom_range(99) < 3);
      case ($urandom_range(3))
        0:       n_jpc = $urandom;
        1:       n_jpc = 32'hFFFF_FFF0 + ($urandom_range(3) << 2);
        default: n_jpc = $urandom_range(1023) & ~32'h3;
      endcase
      n_rst = (k >= 2000 && k < 2002);
      tick();
    end

    n_jv = 1'b0; n_hold = 1'b0; n_gnt = 1'b1; rprob = 100;
    repeat (10) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
